// File: rtl/gpio_irq_ctrl_if.sv
// rtl/gpio_irq_ctrl_if.sv - register bus interface for the GPIO interrupt controller
interface gpio_irq_ctrl_if;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - 72-pin rising-edge capture with per-bank masked level interrupts
module gpio_irq_ctrl #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] MASK_RESET  = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [71:0]          gpio_in,
    gpio_irq_ctrl_if.slave       bus,
    output logic [2:0]           irq
);

    // Pins live in one flat 72-bit vector: bank 0 = [31:0], bank 1 = [63:32],
    // bank 2 = [71:64]. Bank 2 has no storage above bit 7, so its upper
    // register bits read 0 and can never contribute to irq.

    logic [71:0] sync_q [SYNC_STAGES];
    logic [71:0] sync_d [SYNC_STAGES];
    logic [71:0] prev_q, prev_d;
    logic [71:0] mask_q, mask_d;
    logic [71:0] capture_q, capture_d;
    logic [2:0]  irq_q, irq_d;
    logic [31:0] readdata_q, readdata_d;

    logic [71:0] pin_sync;
    logic [71:0] rise;
    logic [71:0] status;
    logic [71:0] lane;
    logic [71:0] wr_placed;
    logic [1:0]  bank_sel;
    logic [1:0]  reg_sel;
    logic        wr_mask;
    logic        wr_clear;

    // Extract one bank's 32-bit register view from a flat 72-bit vector.
    function automatic logic [31:0] bank_word(input logic [71:0] v, input logic [1:0] b);
        logic [31:0] w;
        case (b)
            2'd0:    w = v[31:0];
            2'd1:    w = v[63:32];
            2'd2:    w = {24'h0, v[71:64]};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Bit positions in the flat vector that belong to bank b.
    function automatic logic [71:0] bank_lane(input logic [1:0] b);
        logic [71:0] l;
        case (b)
            2'd0:    l = {40'h0, 32'hFFFF_FFFF};
            2'd1:    l = {8'h0, 32'hFFFF_FFFF, 32'h0};
            2'd2:    l = {8'hFF, 64'h0};
            default: l = 72'h0;
        endcase
        return l;
    endfunction

    // Place a 32-bit write word at bank b's position in the flat vector.
    function automatic logic [71:0] bank_place(input logic [31:0] w, input logic [1:0] b);
        logic [71:0] p;
        case (b)
            2'd0:    p = {40'h0, w};
            2'd1:    p = {8'h0, w, 32'h0};
            2'd2:    p = {w[7:0], 64'h0};
            default: p = 72'h0;
        endcase
        return p;
    endfunction

    // Synchronizer chain, edge detector and bus decode.
    always_comb begin
        sync_d[0] = gpio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        pin_sync = sync_q[SYNC_STAGES-1];
        prev_d   = pin_sync;
        rise     = pin_sync & ~prev_q;
        status   = capture_q & mask_q;

        bank_sel  = bus.avs_address[3:2];
        reg_sel   = bus.avs_address[1:0];
        lane      = bank_lane(bank_sel);
        wr_placed = bank_place(bus.avs_writedata, bank_sel) & lane;
        wr_mask   = bus.avs_write && (reg_sel == 2'd1);
        wr_clear  = bus.avs_write && (reg_sel == 2'd2);
    end

    // Register updates: a new edge is ORed in after the W1C clear so set wins.
    always_comb begin
        mask_d    = mask_q;
        capture_d = capture_q;
        if (wr_mask) begin
            mask_d = (mask_q & ~lane) | wr_placed;
        end
        if (wr_clear) begin
            capture_d = capture_q & ~wr_placed;
        end
        capture_d = capture_d | rise;

        irq_d = {|status[71:64], |status[63:32], |status[31:0]};
    end

    // Read mux samples pre-write state; data holds between reads.
    always_comb begin
        readdata_d = readdata_q;
        if (bus.avs_read) begin
            case (reg_sel)
                2'd0:    readdata_d = bank_word(pin_sync, bank_sel);
                2'd1:    readdata_d = bank_word(mask_q, bank_sel);
                2'd2:    readdata_d = bank_word(capture_q, bank_sel);
                default: readdata_d = bank_word(status, bank_sel);
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            mask_q     <= {MASK_RESET[7:0], MASK_RESET, MASK_RESET};
            capture_q  <= '0;
            irq_q      <= '0;
            readdata_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q     <= prev_d;
            mask_q     <= mask_d;
            capture_q  <= capture_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign irq              = irq_q;
    assign bus.avs_readdata = readdata_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - directed self-checking bench for gpio_irq_ctrl
module tb_gpio_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [71:0] gpio_in = '0;
    logic [2:0]  irq;
    int          total = 0;
    int          bad = 0;
    logic [31:0] rd;

    gpio_irq_ctrl_if bus ();

    gpio_irq_ctrl #(.SYNC_STAGES(2), .MASK_RESET(32'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .gpio_in (gpio_in),
        .bus     (bus.slave),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        tick();
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic pulse(input int pin, input int len);
        gpio_in[pin] = 1'b1;
        ticks(len);
        gpio_in[pin] = 1'b0;
    endtask

    task automatic clear_all();
        bus_write(4'h2, 32'hFFFF_FFFF);
        bus_write(4'h6, 32'hFFFF_FFFF);
        bus_write(4'hA, 32'hFFFF_FFFF);
        ticks(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ticks(3);
        reset_n = 1'b1;
        tick();
        total++; if (irq !== 3'b000) begin bad++; $display("FAIL reset_irq got=%b exp=000", irq); end
        total++; if (bus.avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", bus.avs_readdata); end
        bus_read(4'h1, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_mask0 got=%h exp=0", rd); end
        bus_read(4'h6, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_capture1 got=%h exp=0", rd); end
    endtask

    task automatic test_data();
        gpio_in = 72'hA5_1234_5678_9ABC_DEF0;
        ticks(3);
        bus_read(4'h0, rd);
        total++; if (rd !== 32'h9ABC_DEF0) begin bad++; $display("FAIL data0 got=%h exp=9abcdef0", rd); end
        bus_read(4'h4, rd);
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL data1 got=%h exp=12345678", rd); end
        bus_read(4'h8, rd);
        total++; if (rd !== 32'h0000_00A5) begin bad++; $display("FAIL data2 got=%h exp=000000a5", rd); end
        gpio_in = '0;
        ticks(4);
        clear_all();
    endtask

    task automatic test_basic_edge();
        bus_write(4'h1, 32'h20);
        gpio_in[5] = 1'b1;
        tick();
        tick();
        gpio_in[5] = 1'b0;
        tick();
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq[0]); end
        tick();
        total++; if (irq[0] !== 1'b1) begin bad++; $display("FAIL irq_latency got=%b exp=1", irq[0]); end
        bus_read(4'h2, rd);
        total++; if (rd !== 32'h20) begin bad++; $display("FAIL capture0_pin5 got=%h exp=00000020", rd); end
        bus_write(4'h2, 32'h20);
        total++; if (irq[0] !== 1'b1) begin bad++; $display("FAIL irq_clear_same_edge got=%b exp=1", irq[0]); end
        tick();
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL irq_clear_next_edge got=%b exp=0", irq[0]); end
        bus_read(4'h2, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL capture0_cleared got=%h exp=0", rd); end
    endtask

    task automatic test_banks();
        bus_write(4'h5, 32'hFFFF_FFFF);
        pulse(40, 2);
        ticks(4);
        bus_read(4'h6, rd);
        total++; if (rd !== 32'h100) begin bad++; $display("FAIL capture1_pin40 got=%h exp=00000100", rd); end
        total++; if (irq !== 3'b010) begin bad++; $display("FAIL irq_bank1 got=%b exp=010", irq); end
        bus_write(4'h9, 32'hFF);
        pulse(70, 2);
        ticks(4);
        bus_read(4'hA, rd);
        total++; if (rd !== 32'h40) begin bad++; $display("FAIL capture2_pin70 got=%h exp=00000040", rd); end
        total++; if (irq !== 3'b110) begin bad++; $display("FAIL irq_bank12 got=%b exp=110", irq); end
        clear_all();
        total++; if (irq !== 3'b000) begin bad++; $display("FAIL irq_after_clear got=%b exp=000", irq); end
    endtask

    task automatic test_mask_enable();
        bus_write(4'h1, 32'h0);
        pulse(0, 2);
        ticks(4);
        bus_read(4'h2, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL capture0_masked got=%h exp=00000001", rd); end
        bus_read(4'h3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL status0_masked got=%h exp=0", rd); end
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", irq[0]); end
        bus_write(4'h1, 32'h1);
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL irq_unmask_same_edge got=%b exp=0", irq[0]); end
        tick();
        total++; if (irq[0] !== 1'b1) begin bad++; $display("FAIL irq_unmask_next_edge got=%b exp=1", irq[0]); end
        bus_read(4'h3, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL status0_unmasked got=%h exp=00000001", rd); end
        bus_write(4'h1, 32'h0);
        tick();
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL irq_remask got=%b exp=0", irq[0]); end
        bus_read(4'h2, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL capture0_kept got=%h exp=00000001", rd); end
    endtask

    task automatic test_collision_and_bus();
        gpio_in[3] = 1'b1;
        tick();
        tick();
        bus_write(4'h2, 32'h8);
        gpio_in[3] = 1'b0;
        bus_read(4'h2, rd);
        total++; if (rd !== 32'h9) begin bad++; $display("FAIL set_wins got=%h exp=00000009", rd); end
        bus_write(4'hA, 32'hFFFF_FFFF);
        bus_read(4'hA, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL capture2_cleared got=%h exp=0", rd); end
        bus_write(4'hC, 32'hFFFF_FFFF);
        bus_read(4'hC, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL bank3_read got=%h exp=0", rd); end
        bus_write(4'h9, 32'hFFFF_FFFF);
        bus_read(4'h9, rd);
        total++; if (rd !== 32'hFF) begin bad++; $display("FAIL mask2_upper got=%h exp=000000ff", rd); end
        bus_write(4'h1, 32'h1);
        bus.avs_address   = 4'h1;
        bus.avs_writedata = 32'h55;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        total++; if (bus.avs_readdata !== 32'h1) begin bad++; $display("FAIL rw_prewrite got=%h exp=00000001", bus.avs_readdata); end
        ticks(3);
        total++; if (bus.avs_readdata !== 32'h1) begin bad++; $display("FAIL readdata_hold got=%h exp=00000001", bus.avs_readdata); end
        bus_read(4'h1, rd);
        total++; if (rd !== 32'h55) begin bad++; $display("FAIL rw_postwrite got=%h exp=00000055", rd); end
        clear_all();
    endtask

    task automatic test_sweep();
        logic [71:0] exp_cap;
        logic [31:0] c0, c1, c2;
        logic [2:0]  exp_irq;
        bus_write(4'h1, 32'hFFFF_FFFF);
        bus_write(4'h5, 32'hFFFF_FFFF);
        bus_write(4'h9, 32'hFFFF_FFFF);
        for (int p = 0; p < 72; p++) begin
            clear_all();
            pulse(p, 2);
            ticks(4);
            bus_read(4'h2, c0);
            bus_read(4'h6, c1);
            bus_read(4'hA, c2);
            exp_cap = '0;
            exp_cap[p] = 1'b1;
            exp_irq = (p < 32) ? 3'b001 : ((p < 64) ? 3'b010 : 3'b100);
            total++;
            if ({c2[7:0], c1, c0} !== exp_cap || c2[31:8] !== 24'h0) begin
                bad++; $display("FAIL sweep_capture pin=%0d got=%h_%h_%h exp=%h", p, c2, c1, c0, exp_cap);
            end
            total++;
            if (irq !== exp_irq) begin
                bad++; $display("FAIL sweep_irq pin=%0d got=%b exp=%b", p, irq, exp_irq);
            end
        end
        clear_all();
    endtask

    task automatic test_reset_midop();
        pulse(10, 2);
        ticks(4);
        total++; if (irq !== 3'b001) begin bad++; $display("FAIL pending_pin10 got=%b exp=001", irq); end
        reset_n = 1'b0;
        gpio_in[71] = 1'b1;
        tick();
        total++; if (irq !== 3'b000) begin bad++; $display("FAIL reset_drops_irq got=%b exp=000", irq); end
        tick();
        reset_n = 1'b1;
        ticks(4);
        bus_read(4'h2, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL capture0_after_reset got=%h exp=0", rd); end
        total++; if (irq !== 3'b000) begin bad++; $display("FAIL irq_after_reset got=%b exp=000", irq); end
        bus_read(4'hA, rd);
        total++; if (rd !== 32'h80) begin bad++; $display("FAIL pin71_held got=%h exp=00000080", rd); end
        bus_write(4'hA, 32'h80);
        ticks(4);
        bus_read(4'hA, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL pin71_once got=%h exp=0", rd); end
        bus_read(4'h1, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mask0_reset got=%h exp=0", rd); end
        gpio_in[71] = 1'b0;
    endtask

    initial begin
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        test_reset();
        test_data();
        test_basic_edge();
        test_banks();
        test_mask_enable();
        test_collision_and_bus();
        test_sweep();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
